// File: rtl/mdio_responder.sv
// Clause-22 MDIO responder: oversampled MDC/MDIO frame decoder and read-data driver.
// Optional MDIO_RESPONDER_PRE_SUPPRESS_EN accepts ST after a single preamble '1'.
module mdio_responder #(
  parameter logic [4:0] PHY_ADDR     = 5'd1,
  parameter int         PREAMBLE_MIN = 32,
  parameter int         SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mdc,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_t,
  output logic        rd_req,
  output logic [4:0]  rd_addr,
  input  logic [15:0] rd_data,
  output logic        wr_valid,
  output logic [4:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        frame_err,
  output logic        busy
);

`ifdef MDIO_RESPONDER_PRE_SUPPRESS_EN
  localparam logic [5:0] PreReq = 6'd1;
`else
  localparam logic [5:0] PreReq = 6'(PREAMBLE_MIN);
`endif

  typedef enum logic [2:0] {
    S_PRE, S_ST, S_OP, S_ADDR, S_TA, S_DATA, S_IGN
  } state_t;

  logic [SYNC_STAGES-1:0] mdc_sync_q, mdc_sync_d;
  logic [SYNC_STAGES-1:0] mdio_sync_q, mdio_sync_d;
  logic mdc_prev_q, mdc_prev_d;
  logic mdc_rise, bit_in;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [5:0]  pre_q, pre_d;
  logic        op_q, op_d;
  logic        is_rd_q, is_rd_d;
  logic [9:0]  addr_q, addr_d;
  logic        frame_err_q, frame_err_d;

  logic        mdio_o_q, mdio_o_d;
  logic        mdio_t_q, mdio_t_d;
  logic [15:0] sh_q, sh_d;
  logic        rd_req_q, rd_req_d;
  logic [4:0]  rd_addr_q, rd_addr_d;
  logic        wr_valid_q, wr_valid_d;
  logic [4:0]  wr_addr_q, wr_addr_d;
  logic [15:0] wr_data_q, wr_data_d;

  always_comb begin
    mdc_sync_d  = {mdc_sync_q[SYNC_STAGES-2:0], mdc};
    mdio_sync_d = {mdio_sync_q[SYNC_STAGES-2:0], mdio_i};
    mdc_prev_d  = mdc_sync_q[SYNC_STAGES-1];
    mdc_rise    = mdc_sync_q[SYNC_STAGES-1] & ~mdc_prev_q;
    bit_in      = mdio_sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mdc_sync_q  <= '0;
      mdio_sync_q <= '1;
      mdc_prev_q  <= 1'b0;
      state_q     <= S_PRE;
      cnt_q       <= '0;
      pre_q       <= '0;
      op_q        <= 1'b0;
      is_rd_q     <= 1'b0;
      addr_q      <= '0;
      frame_err_q <= 1'b0;
      mdio_o_q    <= 1'b1;
      mdio_t_q    <= 1'b1;
      sh_q        <= '0;
      rd_req_q    <= 1'b0;
      rd_addr_q   <= '0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      mdc_sync_q  <= mdc_sync_d;
      mdio_sync_q <= mdio_sync_d;
      mdc_prev_q  <= mdc_prev_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pre_q       <= pre_d;
      op_q        <= op_d;
      is_rd_q     <= is_rd_d;
      addr_q      <= addr_d;
      frame_err_q <= frame_err_d;
      mdio_o_q    <= mdio_o_d;
      mdio_t_q    <= mdio_t_d;
      sh_q        <= sh_d;
      rd_req_q    <= rd_req_d;
      rd_addr_q   <= rd_addr_d;
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pre_d       = pre_q;
    op_d        = op_q;
    is_rd_d     = is_rd_q;
    addr_d      = addr_q;
    frame_err_d = 1'b0;
    if (mdc_rise) begin
      unique case (state_q)
        S_PRE: begin
          if (bit_in) begin
            pre_d = (pre_q == 6'd63) ? pre_q : pre_q + 6'd1;
          end else begin
            if (pre_q >= PreReq) state_d = S_ST;
            pre_d = '0;
          end
        end
        S_ST: begin
          cnt_d = '0;
          if (bit_in) begin
            state_d = S_OP;
          end else begin
            state_d     = S_PRE;
            frame_err_d = 1'b1;
          end
        end
        S_OP: begin
          if (cnt_q == 5'd0) begin
            op_d  = bit_in;
            cnt_d = 5'd1;
          end else if (op_q ^ bit_in) begin
            is_rd_d = op_q;
            state_d = S_ADDR;
            cnt_d   = '0;
          end else begin
            state_d     = S_PRE;
            cnt_d       = '0;
            frame_err_d = 1'b1;
          end
        end
        S_ADDR: begin
          addr_d = {addr_q[8:0], bit_in};
          cnt_d  = cnt_q + 5'd1;
          if (cnt_q == 5'd9) begin
            cnt_d   = '0;
            state_d = (addr_q[8:4] == PHY_ADDR) ? S_TA : S_IGN;
          end
        end
        S_TA: begin
          // Write TA must be 1 then 0; read TA is ours to drive.
          if (!is_rd_q && (bit_in == cnt_q[0])) begin
            state_d     = S_PRE;
            cnt_d       = '0;
            frame_err_d = 1'b1;
          end else if (cnt_q == 5'd0) begin
            cnt_d = 5'd1;
          end else begin
            state_d = S_DATA;
            cnt_d   = '0;
          end
        end
        S_DATA: begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd15) begin
            state_d = S_PRE;
            cnt_d   = '0;
          end
        end
        S_IGN: begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd17) begin
            state_d = S_PRE;
            cnt_d   = '0;
          end
        end
        default: state_d = S_PRE;
      endcase
    end
  end

  always_comb begin
    mdio_o_d   = mdio_o_q;
    mdio_t_d   = mdio_t_q;
    sh_d       = sh_q;
    rd_req_d   = 1'b0;
    rd_addr_d  = rd_addr_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    if (mdc_rise) begin
      unique case (state_q)
        S_ADDR: begin
          if (cnt_q == 5'd9 && is_rd_q &&
              addr_q[8:4] == PHY_ADDR) begin
            rd_req_d  = 1'b1;
            rd_addr_d = {addr_q[3:0], bit_in};
          end
        end
        S_TA: begin
          if (is_rd_q) begin
            if (cnt_q == 5'd0) begin
              sh_d     = rd_data;
              mdio_o_d = 1'b0;
              mdio_t_d = 1'b0;
            end else begin
              mdio_o_d = sh_q[15];
              sh_d     = {sh_q[14:0], 1'b0};
            end
          end
        end
        S_DATA: begin
          if (is_rd_q) begin
            if (cnt_q == 5'd15) begin
              mdio_o_d = 1'b1;
              mdio_t_d = 1'b1;
            end else begin
              mdio_o_d = sh_q[15];
              sh_d     = {sh_q[14:0], 1'b0};
            end
          end else begin
            sh_d = {sh_q[14:0], bit_in};
            if (cnt_q == 5'd15) begin
              wr_valid_d = 1'b1;
              wr_addr_d  = addr_q[4:0];
              wr_data_d  = {sh_q[14:0], bit_in};
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign mdio_o    = mdio_o_q;
  assign mdio_t    = mdio_t_q;
  assign rd_req    = rd_req_q;
  assign rd_addr   = rd_addr_q;
  assign wr_valid  = wr_valid_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != S_PRE);

endmodule

// File: tb/tb_mdio_responder.sv
// Directed bench for mdio_responder: a bit-banged MDIO master with
// pulse counters, checked with immediate assertions.
module tb_mdio_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mdc = 1'b0;
  logic        mdio_m = 1'b1;
  wire         mdio_i;
  logic        mdio_o, mdio_t;
  logic        rd_req, wr_valid, frame_err, busy;
  logic [4:0]  rd_addr, wr_addr;
  logic [15:0] rd_data = 16'h0000;
  logic [15:0] wr_data;

  int checks = 0;
  int failures = 0;
  int rd_cnt = 0, wr_cnt = 0, err_cnt = 0, tlow_cnt = 0;
  logic [4:0] rd_addr_seen = '0;

  // Shared line: released means the master's level (pull-up when idle).
  assign mdio_i = mdio_t ? mdio_m : mdio_o;

  mdio_responder #(.PHY_ADDR(5'd1)) dut (
    .clk(clk), .rst(rst), .mdc(mdc),
    .mdio_i(mdio_i), .mdio_o(mdio_o), .mdio_t(mdio_t),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_err(frame_err), .busy(busy)
  );

  always #4 clk = ~clk;

  always @(negedge clk) begin
    if (rd_req) begin
      rd_cnt++;
      rd_addr_seen = rd_addr;
    end
    if (wr_valid) wr_cnt++;
    if (frame_err) err_cnt++;
    if (!mdio_t) tlow_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic mbit(input logic b, output logic s);
    mdio_m = b;
    #80;
    s = mdio_i;
    mdc = 1'b1;
    #80;
    mdc = 1'b0;
  endtask

  task automatic frame(input int npre, input logic [1:0] op,
                       input logic [4:0] phy, input logic [4:0] ra,
                       input logic [1:0] ta, input logic [15:0] d,
                       input int nd, output logic [1:0] tav,
                       output logic [15:0] rdv);
    logic s;
    logic rd;
    rd = (op == 2'b10);
    for (int i = 0; i < npre; i++) mbit(1'b1, s);
    mbit(1'b0, s);
    mbit(1'b1, s);
    mbit(op[1], s);
    mbit(op[0], s);
    for (int i = 4; i >= 0; i--) mbit(phy[i], s);
    for (int i = 4; i >= 0; i--) mbit(ra[i], s);
    mbit(rd ? 1'b1 : ta[1], s);
    tav[1] = s;
    mbit(rd ? 1'b1 : ta[0], s);
    tav[0] = s;
    rdv = '0;
    for (int i = 0; i < nd; i++) begin
      mbit(rd ? 1'b1 : d[15-i], s);
      rdv[15-i] = s;
    end
    mdio_m = 1'b1;
    #40;
  endtask

  initial begin
    logic [1:0]  tav;
    logic [15:0] rdv;
    int r0, w0, e0, t0;

    #20;
    chk("rst_mdio_t", mdio_t, 1);
    chk("rst_mdio_o", mdio_o, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rd_req", rd_req, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_frame_err", frame_err, 0);
    #3 rst = 1'b0;
    #100;

    // Write PHY1 reg 0x04 = 0xA5C3
    w0 = wr_cnt; e0 = err_cnt; t0 = tlow_cnt;
    frame(32, 2'b01, 5'd1, 5'h04, 2'b10, 16'hA5C3, 16, tav, rdv);
    chk("wr_count", wr_cnt - w0, 1);
    chk("wr_addr", wr_addr, 5'h04);
    chk("wr_data", wr_data, 16'hA5C3);
    chk("wr_released", tlow_cnt - t0, 0);
    chk("wr_no_err", err_cnt - e0, 0);
    chk("wr_busy_end", busy, 0);

    // Read PHY1 reg 0x02, host data 0x1234
    rd_data = 16'h1234;
    r0 = rd_cnt; t0 = tlow_cnt;
    frame(32, 2'b10, 5'd1, 5'h02, 2'b00, 16'h0000, 16, tav, rdv);
    chk("rd_count", rd_cnt - r0, 1);
    chk("rd_addr", rd_addr_seen, 5'h02);
    chk("rd_ta", tav, 2'b10);
    chk("rd_data", rdv, 16'h1234);
    chk("rd_release", mdio_t, 1);
    chk("rd_drove", (tlow_cnt - t0) > 0, 1);

    // Read to PHY3 is ignored, then PHY1 reg 0x1F
    r0 = rd_cnt; w0 = wr_cnt; e0 = err_cnt; t0 = tlow_cnt;
    frame(32, 2'b10, 5'd3, 5'h05, 2'b00, 16'h0000, 16, tav, rdv);
    chk("ign_rd", rd_cnt - r0, 0);
    chk("ign_wr", wr_cnt - w0, 0);
    chk("ign_err", err_cnt - e0, 0);
    chk("ign_tlow", tlow_cnt - t0, 0);
    chk("ign_data", rdv, 16'hFFFF);
    rd_data = 16'hC0DE;
    frame(32, 2'b10, 5'd1, 5'h1F, 2'b00, 16'h0000, 16, tav, rdv);
    chk("post_ign_rd", rd_cnt - r0, 1);
    chk("post_ign_addr", rd_addr_seen, 5'h1F);
    chk("post_ign_data", rdv, 16'hC0DE);

    // Write with TA=11
    w0 = wr_cnt; e0 = err_cnt;
    frame(32, 2'b01, 5'd1, 5'h06, 2'b11, 16'hFFFF, 16, tav, rdv);
    chk("bad_ta_err", err_cnt - e0, 1);
    chk("bad_ta_wr", wr_cnt - w0, 0);

    // OP=11
    e0 = err_cnt;
    frame(32, 2'b11, 5'd31, 5'd31, 2'b11, 16'hFFFF, 16, tav, rdv);
    chk("bad_op_err", err_cnt - e0, 1);
    chk("bad_op_busy", busy, 0);

    // Reset while responder drives D7
    rd_data = 16'h5AF0;
    w0 = wr_cnt; e0 = err_cnt;
    frame(32, 2'b10, 5'd1, 5'h03, 2'b00, 16'h0000, 8, tav, rdv);
    chk("mid_drive", mdio_t, 0);
    chk("mid_busy", busy, 1);
    chk("mid_hi_bits", rdv[15:8], 8'h5A);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_rel", mdio_t, 1);
    chk("mid_rst_busy", busy, 0);
    #50 rst = 1'b0;
    #100;
    chk("mid_no_wr", wr_cnt - w0, 0);
    chk("mid_no_err", err_cnt - e0, 0);
    rd_data = 16'h9E37;
    r0 = rd_cnt;
    frame(32, 2'b10, 5'd1, 5'h07, 2'b00, 16'h0000, 16, tav, rdv);
    chk("after_rst_rd", rd_cnt - r0, 1);
    chk("after_rst_data", rdv, 16'h9E37);

    // Short 16-bit preamble write
    w0 = wr_cnt; e0 = err_cnt;
    frame(16, 2'b01, 5'd1, 5'h08, 2'b10, 16'hBEEF, 16, tav, rdv);
    chk("short_pre_err", err_cnt - e0, 0);
`ifdef MDIO_RESPONDER_PRE_SUPPRESS_EN
    chk("short_pre_wr", wr_cnt - w0, 1);
    chk("short_pre_data", wr_data, 16'hBEEF);
`else
    chk("short_pre_wr", wr_cnt - w0, 0);
    chk("short_pre_data", wr_data, 16'h0000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
